// File: rtl/t05_sram_responder.sv
// ---------------------------------------------------------------------------
// t05_sram_responder
//
// Purpose:
//   Serves single-entry read/write requests from several pipeline stages
//   against one 32-bit SRAM macro. Each request moves a payload of 1..5
//   words. The word count and payload width depend on the requesting stage.
//   Words go out on consecutive cycles at
//   mem_addr = {select[2:0], addr[6:0], word_index[2:0]}.
//   Reads are assembled into a shadow register. That register is copied to
//   rdata_o only when the request completes, so rdata_o never shows a
//   partially filled payload.
//
// Ports:
//   clk, rst      - clock; asynchronous active-high reset
//   req_wr_en     - write request strobe (wins when both strobes are high)
//   req_r_en      - read request strobe
//   req_select    - requesting stage: 1 HIST, 2 FLV, 3 HTREE, 5 CB, 6 TRN
//   req_addr      - entry index; only bits [6:0] are used
//   req_wdata     - write payload, LSB-aligned
//   busy_o        - high in every state except IDLE
//   done_o        - one-cycle completion pulse
//   err_o         - qualifies done_o; high for an unsupported select
//   rdata_o       - last completed read payload
//   mem_en/mem_we - SRAM macro enable / write enable
//   mem_addr      - SRAM word address
//   mem_wdata     - SRAM write word
//   mem_rdata     - SRAM read word, valid one cycle after a read cycle
//
// Handshake: a request is accepted at a rising edge where the FSM is IDLE
// and req_wr_en or req_r_en is high. There is no ready signal. Strobes seen
// while busy_o is high are dropped, not queued. Completion is the single
// cycle in which done_o is high.
// ---------------------------------------------------------------------------
module t05_sram_responder (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_wr_en,
    input  logic         req_r_en,
    input  logic [3:0]   req_select,
    input  logic [31:0]  req_addr,
    input  logic [128:0] req_wdata,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o,
    output logic [128:0] rdata_o,
    output logic         mem_en,
    output logic         mem_we,
    output logic [12:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    input  logic [31:0]  mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Word count for a select; 0 marks an unsupported select.
    function automatic logic [2:0] sel_words(input logic [3:0] sel);
        case (sel)
            4'd1:    sel_words = 3'd1;
            4'd2:    sel_words = 3'd2;
            4'd3:    sel_words = 3'd3;
            4'd5:    sel_words = 3'd3;
            4'd6:    sel_words = 3'd5;
            default: sel_words = 3'd0;
        endcase
    endfunction

    // Payload width in bits for a select.
    function automatic logic [7:0] sel_width(input logic [3:0] sel);
        case (sel)
            4'd1:    sel_width = 8'd32;
            4'd2:    sel_width = 8'd64;
            4'd3:    sel_width = 8'd71;
            4'd5:    sel_width = 8'd71;
            4'd6:    sel_width = 8'd129;
            default: sel_width = 8'd0;
        endcase
    endfunction

    // Ones in bit positions below the payload width.
    function automatic logic [128:0] width_mask(input logic [7:0] w);
        width_mask = ~({129{1'b1}} << w);
    endfunction

    state_t         state_q, state_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [128:0]   rdata_q, rdata_d;
    logic           mem_en_q, mem_en_d;
    logic           mem_we_q, mem_we_d;
    logic [12:0]    mem_addr_q, mem_addr_d;
    logic [31:0]    mem_wdata_q, mem_wdata_d;
    logic [3:0]     sel_q, sel_d;
    logic [6:0]     addr_q, addr_d;
    // Payload is held 160 bits wide so that every word index 0..4 has a
    // full 32-bit slice. Bits above the payload width stay zero.
    logic [159:0]   wdata_q, wdata_d;
    logic [159:0]   shadow_q, shadow_d;
    logic [2:0]     k_q, k_d;
    // Capture pipeline. A read issued in one cycle returns its data in the
    // next cycle, so the issue and its word index are delayed by one cycle.
    logic           cap_v_q, cap_v_d;
    logic [2:0]     cap_k_q, cap_k_d;

    logic [2:0]     n_cur;
    logic [2:0]     n_req;
    logic [128:0]   req_mask;

    // Address bits [31:7] and shadow bits above 128 carry no information.
    logic           unused_bits;
    assign unused_bits = ^{req_addr[31:7], shadow_d[159:129]};

    assign n_cur    = sel_words(sel_q);
    assign n_req    = sel_words(req_select);
    assign req_mask = width_mask(sel_width(req_select));

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        k_d         = k_q;
        cap_v_d     = mem_en_q & ~mem_we_q;
        cap_k_d     = k_q;

        shadow_d = shadow_q;
        if (cap_v_q) begin
            shadow_d[{cap_k_q, 5'b0} +: 32] = mem_rdata;
        end

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (req_wr_en || req_r_en) begin
                    sel_d   = req_select;
                    addr_d  = req_addr[6:0];
                    wdata_d = {31'b0, req_wdata & req_mask};
                    k_d     = 3'd0;
                    busy_d  = 1'b1;
                    if (n_req == 3'd0) begin
                        // Unsupported select: finish immediately, no access.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        mem_en_d   = 1'b1;
                        mem_we_d   = req_wr_en;
                        mem_addr_d = {req_select[2:0], req_addr[6:0], 3'd0};
                        if (req_wr_en) begin
                            state_d     = S_WRITE;
                            mem_wdata_d = req_wdata[31:0] & req_mask[31:0];
                        end else begin
                            state_d     = S_READ;
                            mem_wdata_d = 32'd0;
                            shadow_d    = '0;
                        end
                    end
                end
            end

            S_WRITE, S_READ: begin
                if (k_q == 3'(n_cur - 3'd1)) begin
                    if (state_q == S_WRITE) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        // The final read word returns during DRAIN.
                        state_d = S_DRAIN;
                    end
                end else begin
                    k_d        = k_q + 3'd1;
                    mem_en_d   = 1'b1;
                    mem_we_d   = (state_q == S_WRITE);
                    mem_addr_d = {sel_q[2:0], addr_q, k_d};
                    if (state_q == S_WRITE) begin
                        mem_wdata_d = wdata_q[{k_d, 5'b0} +: 32];
                    end
                end
            end

            S_DRAIN: begin
                // shadow_d already contains the last word captured this cycle.
                state_d = S_DONE;
                done_d  = 1'b1;
                rdata_d = shadow_d[128:0] & width_mask(sel_width(sel_q));
            end

            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            sel_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            shadow_q    <= '0;
            k_q         <= '0;
            cap_v_q     <= 1'b0;
            cap_k_q     <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            shadow_q    <= shadow_d;
            k_q         <= k_d;
            cap_v_q     <= cap_v_d;
            cap_k_q     <= cap_k_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign rdata_o   = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_t05_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_t05_sram_responder
//
// Self-checking bench for t05_sram_responder. A behavioural SRAM answers
// the DUT's memory port. Each request pushes its expected memory accesses
// onto a queue. A negedge monitor pops the queue and compares each access
// the DUT makes. Completion cycle, err_o and rdata_o are checked against
// values that the bench derives from its own stage table.
// ---------------------------------------------------------------------------
module tb_t05_sram_responder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_wr_en = 1'b0;
    logic         req_r_en = 1'b0;
    logic [3:0]   req_select = '0;
    logic [31:0]  req_addr = '0;
    logic [128:0] req_wdata = '0;
    logic         busy_o;
    logic         done_o;
    logic         err_o;
    logic [128:0] rdata_o;
    logic         mem_en;
    logic         mem_we;
    logic [12:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata = '0;

    t05_sram_responder dut (
        .clk        (clk),
        .rst        (rst),
        .req_wr_en  (req_wr_en),
        .req_r_en   (req_r_en),
        .req_select (req_select),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .rdata_o    (rdata_o),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- counters / scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    int mem_en_cnt = 0;
    logic [45:0]  exp_q[$];       // {we, addr[12:0], wdata[31:0]}
    logic [128:0] last_rdata = '0;
    logic         ones_mode = 1'b0;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // ---------------- SRAM model ----------------
    logic [31:0] sram [0:8191];
    initial begin
        for (int i = 0; i < 8192; i++) sram[i] = '0;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ones_mode ? 32'hFFFF_FFFF : sram[mem_addr];
        end
    end

    // ---------------- access monitor ----------------
    always @(negedge clk) begin
        if (!rst && mem_en) begin
            logic [45:0] e;
            mem_en_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_access", {147'd0, mem_addr}, 160'h1FFFF);
            end else begin
                e = exp_q.pop_front();
                check("acc_we", {159'd0, mem_we}, {159'd0, e[45]});
                check("acc_addr", {147'd0, mem_addr}, {147'd0, e[44:32]});
                if (e[45]) check("acc_wdata", {128'd0, mem_wdata}, {128'd0, e[31:0]});
            end
        end
    end

    // ---------------- stage table (bench side) ----------------
    function automatic int tb_words(input logic [3:0] s);
        case (s)
            4'd1: return 1;
            4'd2: return 2;
            4'd3: return 3;
            4'd5: return 3;
            4'd6: return 5;
            default: return 0;
        endcase
    endfunction

    function automatic int tb_width(input logic [3:0] s);
        case (s)
            4'd1: return 32;
            4'd2: return 64;
            4'd3: return 71;
            4'd5: return 71;
            4'd6: return 129;
            default: return 0;
        endcase
    endfunction

    function automatic logic [159:0] tb_trim(input logic [128:0] v, input int w);
        logic [159:0] p;
        p = {31'd0, v};
        for (int i = 0; i < 160; i++) if (i >= w) p[i] = 1'b0;
        return p;
    endfunction

    task automatic push_accesses(input logic we, input logic [3:0] sel,
                                 input logic [6:0] addr, input logic [128:0] data);
        logic [159:0] p;
        logic [2:0]   kk;
        p = tb_trim(data, tb_width(sel));
        for (int k = 0; k < tb_words(sel); k++) begin
            kk = 3'(k);
            exp_q.push_back({we, sel[2:0], addr, kk, (we ? p[32*k +: 32] : 32'd0)});
        end
    endtask

    // ---------------- driver ----------------
    // Called at a negedge. Issues a request and follows it to completion.
    // exp_rd is the raw payload expected on a read; the bench trims it.
    task automatic do_req(input logic wr, input logic rd, input logic [3:0] sel,
                          input logic [6:0] addr, input logic [128:0] wdata,
                          input int pulse_c, input logic [128:0] exp_rd);
        int           n;
        int           exp_cycle;
        logic         exp_err;
        logic         is_rd;
        logic         seen;
        logic [31:0]  ra;
        logic [159:0] exp_data;

        n         = tb_words(sel);
        exp_err   = (n == 0);
        is_rd     = !wr && rd;
        exp_cycle = exp_err ? 1 : (wr ? n + 1 : n + 2);
        exp_data  = (is_rd && !exp_err) ? tb_trim(exp_rd, tb_width(sel)) : {31'd0, last_rdata};
        if (!exp_err) push_accesses(wr, sel, addr, wdata);

        mem_en_cnt = 0;
        ra         = $urandom();
        ra[6:0]    = addr;
        req_wr_en  = wr;
        req_r_en   = rd;
        req_select = sel;
        req_addr   = ra;
        req_wdata  = wdata;
        @(posedge clk);
        seen = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("busy_cycle1", {159'd0, busy_o}, 160'd1);
                req_wr_en  = 1'b0;
                req_select = 4'($urandom());
                req_addr   = $urandom();
                req_wdata  = {1'b1, $urandom(), $urandom(), $urandom(), $urandom()};
            end
            req_r_en = (c == pulse_c);
            if (done_o) begin
                check("done_cycle", 160'(c), 160'(exp_cycle));
                check("err", {159'd0, err_o}, {159'd0, exp_err});
                check("busy_in_done", {159'd0, busy_o}, 160'd1);
                check("rdata", {31'd0, rdata_o}, exp_data);
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("done_timeout", 160'd0, 160'd1);
        req_r_en = 1'b0;
        @(negedge clk);
        check("idle_done_low", {158'd0, done_o, busy_o}, 160'd0);
        check("mem_en_count", 160'(mem_en_cnt), 160'(n));
        check("exp_q_empty", 160'(exp_q.size()), 160'd0);
        exp_q.delete();
        last_rdata = exp_data[128:0];
    endtask

    // ---------------- main sequence ----------------
    logic [128:0] trn_val;
    logic [128:0] rv;
    logic [3:0]   sel_tab [0:4];

    initial begin
        sel_tab[0] = 4'd1; sel_tab[1] = 4'd2; sel_tab[2] = 4'd3;
        sel_tab[3] = 4'd5; sel_tab[4] = 4'd6;
        trn_val = 129'h1_FEDCBA98_76543210_FEDCBA98_76543210;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_outs", {154'd0, busy_o, done_o, err_o, mem_en, mem_we, 1'b0}, 160'd0);
        check("rst_mem_addr", {147'd0, mem_addr}, 160'd0);
        check("rst_mem_wdata", {128'd0, mem_wdata}, 160'd0);
        check("rst_rdata", {31'd0, rdata_o}, 160'd0);
        rst = 1'b0;
        @(negedge clk);

        // HIST write then read
        do_req(1'b1, 1'b0, 4'd1, 7'd10, 129'd7, 0, '0);
        do_req(1'b0, 1'b1, 4'd1, 7'd10, '0, 0, 129'd7);

        // TRN write/read of the full 129-bit payload
        do_req(1'b1, 1'b0, 4'd6, 7'd3, trn_val, 0, '0);
        do_req(1'b0, 1'b1, 4'd6, 7'd3, '0, 0, trn_val);

        // HTREE read with the SRAM answering all ones
        ones_mode = 1'b1;
        do_req(1'b0, 1'b1, 4'd3, 7'd20, '0, 0, {129{1'b1}});
        ones_mode = 1'b0;

        // Unsupported select 4 read: error, rdata unchanged
        do_req(1'b0, 1'b1, 4'd4, 7'd5, '0, 0, '0);

        // FLV write with a read strobe pulsed while busy
        rv = {1'b1, $urandom(), $urandom(), $urandom(), $urandom()};
        do_req(1'b1, 1'b0, 4'd2, 7'd33, rv, 1, '0);
        do_req(1'b0, 1'b1, 4'd2, 7'd33, '0, 0, rv);

        // CB with both strobes high is a write
        rv = {1'b1, $urandom(), $urandom(), $urandom(), $urandom()};
        do_req(1'b1, 1'b1, 4'd5, 7'd127, rv, 0, '0);
        do_req(1'b0, 1'b1, 4'd5, 7'd127, '0, 0, rv);

        // Unsupported select 0 write
        do_req(1'b1, 1'b0, 4'd0, 7'd1, rv, 0, '0);

        // Reset during cycle 2 of a TRN write
        mem_en_cnt = 0;
        push_accesses(1'b1, 4'd6, 7'd3, trn_val);
        req_wr_en  = 1'b1;
        req_select = 4'd6;
        req_addr   = 32'd3;
        req_wdata  = trn_val;
        @(posedge clk);
        @(negedge clk);
        req_wr_en = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_mem_en", {159'd0, mem_en}, 160'd0);
        check("abort_busy", {159'd0, busy_o}, 160'd0);
        check("abort_rdata", {31'd0, rdata_o}, 160'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", {158'd0, done_o, mem_en}, 160'd0);
        end
        check("abort_mem_en_count", 160'(mem_en_cnt), 160'd2);
        exp_q.delete();
        last_rdata = '0;
        rst = 1'b0;
        @(negedge clk);
        do_req(1'b0, 1'b1, 4'd1, 7'd10, '0, 0, 129'd7);

        // Random write/readback over the supported stages
        for (int t = 0; t < 6; t++) begin
            logic [3:0] s;
            logic [6:0] a;
            s  = sel_tab[$urandom_range(0, 4)];
            a  = 7'($urandom_range(0, 127));
            rv = {1'($urandom()), $urandom(), $urandom(), $urandom(), $urandom()};
            do_req(1'b1, 1'b0, s, a, rv, 0, '0);
            do_req(1'b0, 1'b1, s, a, '0, 0, rv);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/t05_sram_responder.md
T05_SRAM_RESPONDER -- requirements
Module: t05_sram_responder

Interface
REQ-001 SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 req_wr_en  in  1  write request strobe from the SRAM interface.
REQ-005 req_r_en  in  1  read request strobe from the SRAM interface.
REQ-006 req_select  in  4  requesting stage: 1 HIST, 2 FLV, 3 HTREE, 5 CB, 6 TRN; all other values unsupported.
REQ-007 req_addr  in  32  entry index; only bits [6:0] are used.
REQ-008 req_wdata  in  129  write payload, LSB-aligned.
REQ-009 busy_o  out  1  high while a request is in progress.
REQ-010 done_o  out  1  one-cycle pulse at request completion.
REQ-011 err_o  out  1  qualifies done_o; high for an unsupported select.
REQ-012 rdata_o  out  129  assembled read data.
REQ-013 mem_en  out  1  SRAM macro enable.
REQ-014 mem_we  out  1  SRAM macro write enable.
REQ-015 mem_addr  out  13  SRAM word address.
REQ-016 mem_wdata  out  32  SRAM write word.
REQ-017 mem_rdata  in  32  SRAM read word, valid exactly 1 cycle after an mem_en=1, mem_we=0 cycle.

Function
REQ-018 Word count N by select: HIST 1, FLV 2, HTREE 3, CB 3, TRN 5.
REQ-019 Payload width by select: HIST 32, FLV 64, HTREE 71, CB 71, TRN 129.
REQ-020 mem_addr SHALL equal {req_select[2:0], req_addr[6:0], k[2:0]}, where k is the word index 0..N-1.
REQ-021 Word k SHALL carry payload bits [32k+31:32k]; bits at or above the payload width are zero.
REQ-022 FSM states SHALL be IDLE, WRITE, READ, DRAIN, DONE.
REQ-023 Acceptance SHALL occur only in IDLE at an edge where req_wr_en or req_r_en is high.
REQ-024 At acceptance, select, addr[6:0] and wdata SHALL be latched; later input changes have no effect until the next acceptance.
REQ-025 If req_wr_en and req_r_en are both high, the request SHALL be treated as a write.
REQ-026 Requests while busy_o=1 SHALL be ignored, not queued.
REQ-027 busy_o SHALL be high in every state except IDLE; it rises the cycle after acceptance.
REQ-028 Write timing: cycles 1..N have mem_en=1, mem_we=1, word k in cycle k+1; DONE in cycle N+1.
REQ-029 Read timing: cycles 1..N have mem_en=1, mem_we=0 and issue words back-to-back; mem_rdata is captured one cycle later into rdata_o[32k+31:32k].
REQ-030 Read timing: DRAIN covers the final capture; DONE in cycle N+2.
REQ-031 On completion of a read, rdata_o bits at or above the payload width SHALL be zero.
REQ-032 rdata_o SHALL hold its value until the next read completes; writes and errors leave it unchanged.
REQ-033 A read SHALL NOT update rdata_o partially before done_o; it assembles into a shadow register copied at DONE.
REQ-034 An unsupported select SHALL produce no memory access and go directly to DONE in cycle 1 with err_o=1.
REQ-035 DONE SHALL last one cycle: done_o=1, busy_o=1, then return to IDLE.
REQ-036 A new request may be accepted on the edge leaving DONE+1, i.e. first IDLE cycle.
REQ-037 mem_en and mem_we SHALL be 0 in IDLE, DRAIN (write side) and DONE.

Reset
REQ-038 rst=1 SHALL immediately force: state IDLE, busy_o=0, done_o=0, err_o=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata_o=0, and clear all latches.
REQ-039 Reset mid-operation SHALL abort the access with no further mem_en cycles and no done_o.

Verification
REQ-040 HIST write, addr 10, wdata 7 -> one write at mem_addr 0x0450 with wdata 0x00000007; done_o in cycle 2; a following read returns rdata_o=7 with done_o in cycle 3.
REQ-041 TRN write of 129'h1_FEDCBA98_76543210_FEDCBA98_76543210 at addr 3 -> five writes at mem_addr 0x1818..0x181C; readback returns an identical value with done_o in cycle 7.
REQ-042 HTREE read where the SRAM returns 0xFFFFFFFF for every word -> rdata_o = 71 ones with bits [128:71]=0.
REQ-043 select=4 with r_en=1 -> no mem_en, done_o and err_o high in cycle 1, rdata_o unchanged.
REQ-044 Assert rst during cycle 2 of a TRN write -> mem_en drops the same cycle, no done_o; the next HIST read after reset completes normally.
REQ-045 Pulse req_r_en during a busy FLV write -> request ignored; exactly 2 mem_en cycles observed.
